// File: rtl/counter_ctrl.sv
// Command/response controller for four counter channels: holds per-channel
// preset and type, pulses per-channel counter resets, and reads back accumulators/flags.
module counter_ctrl #(
  parameter  int unsigned PRESET_W = 8,
  parameter  int unsigned ACC_W    = 8,
  parameter  int unsigned TYPE_W   = 2,
  localparam int unsigned NCH      = 4,
  localparam int unsigned DATA_W   = (PRESET_W > ACC_W) ? PRESET_W : ACC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [1:0]              cmd_ch,
  input  logic [DATA_W-1:0]       cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic [NCH*PRESET_W-1:0] ch_preset,
  output logic [NCH*TYPE_W-1:0]   ch_type,
  output logic [NCH-1:0]          ch_reset,
  input  logic [NCH*ACC_W-1:0]    ch_acc,
  input  logic [NCH-1:0]          ch_dn,
  input  logic [NCH-1:0]          ch_cu,
  input  logic [NCH-1:0]          ch_cd
);

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_WR_PRESET = 3'd1;
  localparam logic [2:0] OP_WR_TYPE   = 3'd2;
  localparam logic [2:0] OP_CLEAR     = 3'd3;
  localparam logic [2:0] OP_RD_ACC    = 3'd4;
  localparam logic [2:0] OP_RD_STATUS = 3'd5;

  localparam logic [TYPE_W-1:0] TYPE_UP = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] TYPE_DN = TYPE_W'(2);

  typedef enum logic [2:0] {IDLE, EXEC, CLR1, CLR2, RESP} state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [PRESET_W-1:0] preset_q [NCH];
  logic [PRESET_W-1:0] preset_d [NCH];
  logic [TYPE_W-1:0]   type_q [NCH];
  logic [TYPE_W-1:0]   type_d [NCH];
  logic [NCH-1:0]      ch_reset_q, ch_reset_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          ch_q, ch_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ACC_W-1:0]    acc_w [NCH];

  // Flat bus <-> per-channel views
  for (genvar n = 0; n < NCH; n++) begin : g_ch
    assign ch_preset[n*PRESET_W +: PRESET_W] = preset_q[n];
    assign ch_type[n*TYPE_W +: TYPE_W]       = type_q[n];
    assign acc_w[n]                          = ch_acc[n*ACC_W +: ACC_W];
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign ch_reset  = ch_reset_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      preset_q    <= '{default: '0};
      type_q      <= '{default: TYPE_UP};
      ch_reset_q  <= '1;
      op_q        <= OP_NOP;
      ch_q        <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      preset_q    <= preset_d;
      type_q      <= type_d;
      ch_reset_q  <= ch_reset_d;
      op_q        <= op_d;
      ch_q        <= ch_d;
      data_q      <= data_d;
    end
  end

  // Next-state and registered-output logic; ch_reset is held through EXEC->CLR1->CLR2
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    preset_d    = preset_q;
    type_d      = type_q;
    ch_reset_d  = '0;
    op_d        = op_q;
    ch_d        = ch_q;
    data_d      = data_q;
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          ch_d        = cmd_ch;
          data_d      = cmd_data;
          cmd_ready_d = 1'b0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        case (op_q)
          OP_NOP: ;
          OP_WR_PRESET: begin
            preset_d[ch_q] = data_q[PRESET_W-1:0];
            rsp_data_d     = DATA_W'(data_q[PRESET_W-1:0]);
          end
          OP_WR_TYPE: begin
            if (data_q[TYPE_W-1:0] == TYPE_UP || data_q[TYPE_W-1:0] == TYPE_DN) begin
              type_d[ch_q] = data_q[TYPE_W-1:0];
              rsp_data_d   = DATA_W'(data_q[TYPE_W-1:0]);
            end else begin
              rsp_err_d = 1'b1;
            end
          end
          OP_CLEAR: begin
            state_d          = CLR1;
            rsp_valid_d      = 1'b0;
            ch_reset_d[ch_q] = 1'b1;
          end
          OP_RD_ACC:    rsp_data_d = DATA_W'(acc_w[ch_q]);
          OP_RD_STATUS: rsp_data_d = DATA_W'({ch_cd[ch_q], ch_cu[ch_q], ch_dn[ch_q]});
          default:      rsp_err_d  = 1'b1;
        endcase
      end
      CLR1: begin
        ch_reset_d[ch_q] = 1'b1;
        state_d          = CLR2;
      end
      CLR2: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: transaction-level reference model,
// per-cycle output comparison, directed scenarios plus randomized commands.
module tb_counter_ctrl;

  localparam int unsigned PW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned TW = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_ch;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [31:0] ch_preset;
  logic [7:0]  ch_type;
  logic [3:0]  ch_reset;
  logic [31:0] ch_acc;
  logic [3:0]  ch_dn, ch_cu, ch_cd;

  always #5 clk = ~clk;

  counter_ctrl #(.PRESET_W(PW), .ACC_W(AW), .TYPE_W(TW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ch(cmd_ch), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ch_preset(ch_preset), .ch_type(ch_type), .ch_reset(ch_reset),
    .ch_acc(ch_acc), .ch_dn(ch_dn), .ch_cu(ch_cu), .ch_cd(ch_cd)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state and current expectations
  logic [7:0] m_preset [4];
  logic [1:0] m_type [4];
  logic       exp_rdy, exp_vld, exp_err;
  logic [7:0] exp_data;
  logic [3:0] exp_chrst;
  logic [7:0] got_data;
  logic       got_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk_preset();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_preset[i];
    return r;
  endfunction

  function automatic logic [7:0] pk_type();
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[i*2 +: 2] = m_type[i];
    return r;
  endfunction

  task automatic check_state();
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    chk("ch_reset", 32'(ch_reset), 32'(exp_chrst));
    chk("ch_preset", ch_preset, pk_preset());
    chk("ch_type", 32'(ch_type), 32'(pk_type()));
    if (exp_vld) begin
      chk("rsp_data", 32'(rsp_data), 32'(exp_data));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_preset[i] = 8'h00;
      m_type[i]   = 2'b01;
    end
    exp_rdy   = 1'b0;
    exp_vld   = 1'b0;
    exp_chrst = 4'hF;
  endtask

  // While the controller is busy, optionally present a garbage command it must ignore
  task automatic drive_busy(input bit junk);
    cmd_valid = junk;
    if (junk) begin
      cmd_op   = 3'($urandom);
      cmd_ch   = 2'($urandom);
      cmd_data = 8'($urandom);
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [1:0] ch, input logic [7:0] data,
                        input int unsigned hold, input bit junk);
    logic [7:0] rd;
    logic       re;
    logic       type_ok;
    rd      = 8'h00;
    re      = 1'b0;
    type_ok = (data[1:0] == 2'b01) || (data[1:0] == 2'b10);
    case (op)
      3'd1:    rd = data;
      3'd2:    if (type_ok) rd = {6'b0, data[1:0]}; else re = 1'b1;
      3'd4:    rd = ch_acc[int'(ch)*8 +: 8];
      3'd5:    rd = {5'b0, ch_cd[ch], ch_cu[ch], ch_dn[ch]};
      3'd6,
      3'd7:    re = 1'b1;
      default: rd = 8'h00;
    endcase
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = ch;
    cmd_data  = data;
    exp_rdy   = 1'b0;
    exp_vld   = 1'b0;
    exp_chrst = 4'h0;
    tick();
    drive_busy(junk);
    if (op == 3'd3) begin
      exp_chrst = 4'b0001 << ch;
      tick();
      drive_busy(junk);
      tick();
      drive_busy(junk);
      exp_chrst = 4'h0;
    end
    if (op == 3'd1) m_preset[ch] = data;
    if (op == 3'd2 && type_ok) m_type[ch] = data[1:0];
    exp_vld  = 1'b1;
    exp_data = rd;
    exp_err  = re;
    tick();
    got_data = rsp_data;
    got_err  = rsp_err;
    for (int unsigned k = 0; k < hold; k++) begin
      drive_busy(junk);
      tick();
    end
    rsp_ready = 1'b1;
    exp_vld   = 1'b0;
    exp_rdy   = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_ch    = 2'd0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b0;
    ch_acc    = 32'h0;
    ch_dn     = 4'h0;
    ch_cu     = 4'h0;
    ch_cd     = 4'h0;
    exp_data  = 8'h00;
    exp_err   = 1'b0;
    model_reset();

    // Reset values
    tick();
    tick();
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_ch_type", 32'(ch_type), 32'h55);
    reset   = 1'b0;
    exp_rdy   = 1'b1;
    exp_chrst = 4'h0;
    tick();

    // Preset write echo and placement
    do_cmd(3'd1, 2'd2, 8'h2A, 0, 1'b0);
    chk("wrp_echo", 32'(got_data), 32'h2A);
    chk("wrp_preset", ch_preset, 32'h002A_0000);

    // Type writes: legal then illegal
    do_cmd(3'd2, 2'd1, 8'h02, 0, 1'b0);
    chk("wrt_ok_err", 32'(got_err), 32'h0);
    do_cmd(3'd2, 2'd1, 8'h03, 0, 1'b0);
    chk("wrt_bad_err", 32'(got_err), 32'h1);
    chk("wrt_bad_data", 32'(got_data), 32'h0);
    chk("wrt_type", 32'(ch_type), 32'h59);

    // Clear channel 3
    do_cmd(3'd3, 2'd3, 8'hFF, 0, 1'b0);
    chk("clr_data", 32'(got_data), 32'h0);

    // Reads with a stalled response and ignored commands during the stall
    ch_acc = 32'h0000_0055;
    ch_dn  = 4'b0001;
    ch_cu  = 4'b0001;
    ch_cd  = 4'b0000;
    do_cmd(3'd4, 2'd0, 8'h00, 5, 1'b1);
    chk("rdacc_data", 32'(got_data), 32'h55);
    do_cmd(3'd5, 2'd0, 8'h00, 0, 1'b0);
    chk("rdsts_data", 32'(got_data), 32'h03);

    // Illegal opcode
    do_cmd(3'd7, 2'd1, 8'hA5, 0, 1'b0);
    chk("illegal_err", 32'(got_err), 32'h1);

    // Reset during CLR1, with a competing write presented throughout
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    cmd_ch    = 2'd1;
    exp_rdy   = 1'b0;
    exp_chrst = 4'h0;
    tick();
    cmd_valid = 1'b0;
    exp_chrst = 4'b0010;
    tick();
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_ch    = 2'd0;
    cmd_data  = 8'hEE;
    model_reset();
    tick();
    tick();
    chk("rst_clr1_chrst", 32'(ch_reset), 32'hF);
    reset     = 1'b0;
    exp_rdy   = 1'b1;
    exp_chrst = 4'h0;
    tick();
    cmd_valid = 1'b0;
    chk("rst_release_rdy", 32'(cmd_ready), 32'h1);

    // Reset while a preset write sits in EXEC discards the write
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_ch    = 2'd1;
    cmd_data  = 8'h77;
    exp_rdy   = 1'b0;
    tick();
    cmd_valid = 1'b0;
    reset     = 1'b1;
    model_reset();
    tick();
    reset     = 1'b0;
    exp_rdy   = 1'b1;
    exp_chrst = 4'h0;
    tick();
    chk("rst_exec_preset", ch_preset, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      ch_acc = $urandom;
      ch_dn  = 4'($urandom);
      ch_cu  = 4'($urandom);
      ch_cd  = 4'($urandom);
      do_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter PRESET_W, default 8, SHALL set the per-channel preset width.
REQ-002 Parameter ACC_W, default 8, SHALL set the per-channel accumulator width.
REQ-003 Parameter TYPE_W, default 2, SHALL set the per-channel type-code width; channel count SHALL be fixed at 4; DATA_W SHALL equal max(PRESET_W, ACC_W).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 cmd_valid  in  1  command present.
REQ-008 cmd_ready  out  1  controller accepts command.
REQ-009 cmd_op  in  3  opcode: 000 NOP, 001 WR_PRESET, 010 WR_TYPE, 011 CLEAR, 100 RD_ACC, 101 RD_STATUS, 110/111 illegal.
REQ-010 cmd_ch  in  2  target channel 0-3.
REQ-011 cmd_data  in  DATA_W  write data (preset in low PRESET_W bits; type in low TYPE_W bits).
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  requester accepts response.
REQ-014 rsp_data  out  DATA_W  read data or write echo.
REQ-015 rsp_err  out  1  command rejected.
REQ-016 ch_preset  out  4*PRESET_W  per-channel preset to counters (channel n at bits [n*PRESET_W +: PRESET_W]).
REQ-017 ch_type  out  4*TYPE_W  per-channel type (01 up, 10 down).
REQ-018 ch_reset  out  4  per-channel counter reset, active-high.
REQ-019 ch_acc  in  4*ACC_W  per-channel accumulator from counters.
REQ-020 ch_dn, ch_cu, ch_cd  in  4 each  per-channel done / count-up / count-down flags.

Function
REQ-021 The FSM SHALL have states IDLE, EXEC, CLR1, CLR2, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-022 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; the FSM SHALL then move IDLE->EXEC; cmd_* SHALL be captured at acceptance and held internally.
REQ-023 In EXEC, WR_PRESET SHALL load ch_preset[ch] from cmd_data[PRESET_W-1:0]; rsp_data SHALL echo the value zero-extended; next state RESP.
REQ-024 In EXEC, WR_TYPE with data 01 or 10 SHALL load ch_type[ch]; any other type code SHALL leave ch_type unchanged and set rsp_err=1, rsp_data=0; next state RESP.
REQ-025 In EXEC, RD_ACC SHALL sample ch_acc[ch] into rsp_data (zero-extended to DATA_W); RD_STATUS SHALL sample {zeros, ch_cd[ch], ch_cu[ch], ch_dn[ch]}; next state RESP.
REQ-026 CLEAR SHALL go EXEC->CLR1->CLR2->RESP, with ch_reset[ch]=1 for exactly two cycles (CLR1, CLR2) and other channels' ch_reset=0; rsp_data=0.
REQ-027 NOP SHALL produce a response with rsp_data=0, rsp_err=0; illegal opcodes SHALL produce rsp_err=1, rsp_data=0, no output change.
REQ-028 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err stable until a rising edge with rsp_ready=1, then RESP->IDLE; rsp_valid SHALL be 0 in all other states.
REQ-029 Latency: accept at edge N -> rsp_valid high from after edge N+1 (N+3 for CLEAR); back-to-back issue SHALL be possible the cycle after response handshake.
REQ-030 cmd_valid while cmd_ready=0 SHALL be ignored; the requester SHALL hold it.
REQ-031 rsp_err SHALL be 0 whenever rsp_data carries a valid result.

Reset
REQ-032 While reset=1: state IDLE, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, ch_preset all 0, ch_type all 01, ch_reset all 1.
REQ-033 First cycle after reset deasserts: cmd_ready=1, ch_reset all 0.
REQ-034 Reset in any state SHALL abort the command with no response; a write not yet performed in EXEC SHALL be discarded; reset wins over simultaneous cmd_valid.

Verification
REQ-035 After reset: WR_PRESET ch2 data 0x2A -> rsp_valid 2 cycles after accept, rsp_data=0x2A, ch_preset[2]=0x2A, others 0.
REQ-036 WR_TYPE ch1 data 10 -> ch_type[1]=10, rsp_err=0; WR_TYPE ch1 data 11 -> rsp_err=1, ch_type[1] stays 10.
REQ-037 CLEAR ch3 -> ch_reset=4'b1000 for exactly 2 cycles, then rsp_valid, rsp_data=0.
REQ-038 ch_acc[0]=0x55, ch_dn[0]=1, ch_cu[0]=1: RD_ACC ch0 -> 0x55; RD_STATUS ch0 -> 0x03.
REQ-039 RD_ACC with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout; new cmd_valid ignored until handshake.
REQ-040 Reset asserted in CLR1 -> no response, all ch_reset=1 during reset, cmd_ready=1 one cycle after release; opcode 111 -> rsp_err=1.
